// File: rtl/button_modesel.sv
// button_modesel: pushbutton conditioner and 2-bit mode selector.
// A raw asynchronous button goes through a 2-flop synchroniser and a
// stability-counter debounce; each debounced press advances sel 0->1->2->3->0.
// Optional feature macro: MODESEL_LONGPRESS_EN. When defined, holding the
// button for 2^LONG_BITS cycles after a press forces sel back to 0 and pulses
// long_press. When undefined, there is no hold timer and long_press is 0.
module button_modesel #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int LONG_BITS     = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  output logic [1:0] sel,
  output logic       pressed,
  output logic       press,
  output logic       long_press
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } state_t;

  logic                     r_s1;
  logic                     r_s2;
  logic [DEBOUNCE_BITS-1:0] r_db_cnt;
  logic                     r_pressed;
  logic                     r_press;
  logic [1:0]               r_sel;
  state_t                   r_state;

  logic w_db_full;
  logic w_accept;
  logic w_rise;

  // The counter saturating while s2 still disagrees means the new level held.
  assign w_db_full = &r_db_cnt;
  assign w_accept  = (r_s2 != r_pressed) && w_db_full;
  assign w_rise    = w_accept && r_s2;

  // Two-flop synchroniser; the only logic that touches the raw button.
  always_ff @(posedge clock) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values, regardless of statement order.
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= button;
      r_s2 <= r_s1;
    end
  end

  // Debounce: accept a new level only after it has been stable long enough.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_press <= w_rise;
      if (r_s2 == r_pressed) begin
        r_db_cnt <= '0;
      end else if (!w_db_full) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end else begin
        r_pressed <= r_s2;
        r_db_cnt  <= '0;
      end
    end
  end

`ifdef MODESEL_LONGPRESS_EN

  logic [LONG_BITS-1:0] r_hold;
  logic                 r_long;

  // Mode FSM with hold timer: advance sel on press, force 0 on a long hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
      r_hold  <= '0;
      r_long  <= 1'b0;
    end else begin
      r_long <= 1'b0;
      case (r_state)
        IDLE: begin
          r_hold <= '0;
          if (w_rise) begin
            r_sel   <= r_sel + 2'd1;
            r_state <= DOWN;
          end
        end
        DOWN: begin
          if (!r_pressed) begin
            r_state <= IDLE;
            r_hold  <= '0;
          end else if (&r_hold) begin
            // The press already advanced sel; a long hold overrides it to 0.
            r_sel   <= 2'b00;
            r_long  <= 1'b1;
            r_state <= LONG;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        LONG: begin
          // Timer frozen so a continued hold never repeats the pulse.
          if (!r_pressed) begin
            r_state <= IDLE;
            r_hold  <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign long_press = r_long;

`else

  // Mode FSM without hold timer: advance sel on press, wait for release.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_sel   <= r_sel + 2'd1;
            r_state <= DOWN;
          end
        end
        DOWN: begin
          if (!r_pressed) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // No long-press detection in this build; the constant keeps LONG_BITS in use.
  assign long_press = |{LONG_BITS{1'b0}};

`endif

  assign sel     = r_sel;
  assign pressed = r_pressed;
  assign press   = r_press;

endmodule

// File: tb/tb_button_modesel.sv
// tb_button_modesel: randomized + directed bench for button_modesel.
// A stimulus process drives one cycle at a time, advances a behavioural
// model and pushes the expected outputs into a scoreboard queue; a monitor
// pops and compares on every falling edge.
module tb_button_modesel;

  localparam int DB = 3;
  localparam int LB = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic [1:0] sel;
  logic       pressed;
  logic       press;
  logic       long_press;

  button_modesel #(
    .DEBOUNCE_BITS(DB),
    .LONG_BITS    (LB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button    (button),
    .sel       (sel),
    .pressed   (pressed),
    .press     (press),
    .long_press(long_press)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sel;
    int pressed;
    int press;
    int long_press;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The synchronised button is the raw button seen two edges late; the
  // debounced level flips once the late level has disagreed with it for
  // 2^DB consecutive edges. Mode arithmetic is plain modulo-4.
  int m_dly[$];
  int m_p, m_run, m_sel, m_down, m_age, m_longdone;

  task automatic model_step(input logic rst, input logic btn);
    exp_t e;
    int   d;
    int   p_old;
    int   rose;
    int   lp;
    rose = 0;
    lp   = 0;
    if (rst) begin
      m_dly.delete();
      m_dly.push_back(0);
      m_dly.push_back(0);
      m_p = 0; m_run = 0; m_sel = 0; m_down = 0; m_age = 0; m_longdone = 0;
    end else begin
      p_old = m_p;
      d = m_dly.pop_front();
      m_dly.push_back(int'(btn));
      if (m_down != 0) begin
        if (p_old == 0) begin
          m_down = 0;
        end else if (m_longdone == 0) begin
          m_age++;
`ifdef MODESEL_LONGPRESS_EN
          if (m_age == (1 << LB)) begin
            lp = 1;
            m_sel = 0;
            m_longdone = 1;
          end
`endif
        end
      end
      if (d != m_p) begin
        m_run++;
        if (m_run == (1 << DB)) begin
          m_p = d;
          m_run = 0;
          if (d == 1) begin
            rose = 1;
            m_sel = (m_sel + 1) % 4;
            m_down = 1;
            m_age = 0;
            m_longdone = 0;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    e.sel = m_sel;
    e.pressed = m_p;
    e.press = rose;
    e.long_press = lp;
    sb_q.push_back(e);
  endtask

  // One clock cycle: drive on the falling edge, model the rising edge.
  task automatic step(input logic rst, input logic btn);
    @(negedge clock);
    reset  = rst;
    button = btn;
    @(posedge clock);
    model_step(rst, btn);
  endtask

  task automatic hold(input logic rst, input logic btn, input int n);
    for (int i = 0; i < n; i++) step(rst, btn);
  endtask

  // Spot check just after an edge, before the next falling edge.
  task automatic spot(input string name, input int exp_sel, input int exp_pressed);
    #1;
    check({name, "_sel"}, 32'(sel), 32'(exp_sel));
    check({name, "_pressed"}, 32'(pressed), 32'(exp_pressed));
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sel", 32'(sel), 32'(e.sel));
        check("pressed", 32'(pressed), 32'(e.pressed));
        check("press", 32'(press), 32'(e.press));
        check("long_press", 32'(long_press), 32'(e.long_press));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lvl;
    int len;
    int long_exp;
`ifdef MODESEL_LONGPRESS_EN
    long_exp = 0;
`else
    long_exp = 3;
`endif

    // 1: reset with button low
    hold(1'b1, 1'b0, 2);
    step(1'b0, 1'b0);
    spot("t1", 0, 0);

    // 2: clean press and release
    hold(1'b0, 1'b1, 20);
    spot("t2_press", 1, 1);
    hold(1'b0, 1'b0, 20);
    spot("t2_release", 1, 0);

    // 3: glitches shorter than the debounce window
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 6);
    hold(1'b0, 1'b0, 20);
    spot("t3", 1, 0);

    // 4: four presses from 0 wrap back to 0
    hold(1'b1, 1'b0, 2);
    for (int k = 0; k < 4; k++) begin
      hold(1'b0, 1'b1, 20);
      hold(1'b0, 1'b0, 20);
    end
    spot("t4", 0, 0);

    // 5: long hold starting from sel=2
    hold(1'b1, 1'b0, 2);
    for (int k = 0; k < 2; k++) begin
      hold(1'b0, 1'b1, 20);
      hold(1'b0, 1'b0, 20);
    end
    hold(1'b0, 1'b1, 60);
    spot("t5_held", long_exp, 1);
    hold(1'b0, 1'b0, 20);
    spot("t5_release", long_exp, 0);

    // 6: reset in the middle of a hold, button kept high
    hold(1'b0, 1'b1, 5);
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b1, 20);
    spot("t6", 1, 1);
    hold(1'b0, 1'b0, 20);

    // random segments, occasional resets and long holds
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        hold(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      end else begin
        lvl = int'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) len = int'($urandom_range(30, 50));
        else len = int'($urandom_range(1, 14));
        hold(1'b0, 1'(lvl), len);
      end
    end

    // let the monitor consume the last entry
    @(negedge clock);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
